// File: rtl/shift_sub_divider.sv
// 8-bit by 4-bit unsigned restoring divider with a start/ready handshake; result = {remainder, quotient}.
// Build option: define DIV_ZERO_CHECK_EN for the one-cycle divide-by-zero path and the dbz flag.
module shift_sub_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  ABus,
  input  logic [3:0]  BBus,
  output logic        ready,
  output logic [11:0] resultBus,
  output logic        dbz
);

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    LOAD = 3'b010,
    SUB  = 3'b100
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  q_q, q_d;
  logic [3:0]  r_q, r_d;
  logic [3:0]  d_q, d_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [4:0]  t;

`ifdef DIV_ZERO_CHECK_EN
  logic        dbz_q, dbz_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef DIV_ZERO_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) dbz_q <= 1'b0;
    else     dbz_q <= dbz_d;
  end
`endif

  // Partial remainder with the next dividend bit appended
  assign t = {r_q, q_q[7]};

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
`ifdef DIV_ZERO_CHECK_EN
    dbz_d   = dbz_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        q_d     = ABus;
        d_d     = BBus;
        r_d     = '0;
        cnt_d   = '0;
        state_d = SUB;
`ifdef DIV_ZERO_CHECK_EN
        dbz_d   = 1'b0;
        // Same result the full step sequence would produce for a zero divisor
        if (BBus == 4'd0) begin
          dbz_d   = 1'b1;
          q_d     = 8'hFF;
          r_d     = ABus[3:0];
          state_d = IDLE;
        end
`endif
      end
      SUB: begin
        // Difference always fits in 4 bits when the compare passes
        if (t >= {1'b0, d_q}) begin
          r_d = t[3:0] - d_q;
          q_d = {q_q[6:0], 1'b1};
        end else begin
          r_d = t[3:0];
          q_d = {q_q[6:0], 1'b0};
        end
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready     = (state_q == IDLE);
  assign resultBus = {r_q, q_q};

`ifdef DIV_ZERO_CHECK_EN
  assign dbz = dbz_q;
`else
  assign dbz = 1'b0;
`endif

endmodule

// File: doc/shift_sub_divider.md
# shift_sub_divider

Sequential 8-bit by 4-bit unsigned restoring divider with the same start/ready handshake as the team's add-shift multiplier. It is the inverse datapath of that multiplier, turning an 8-bit product-width value back into quotient and remainder. It sits beside the multiplier under the same controller. Operands are taken from shared buses, and results are exposed on one result bus.

## Interface
Parameters: none (widths fixed to match multiplier: 4-bit operand, 8-bit wide value).

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- start  in  1  level request to begin a division, sampled in IDLE only
- ABus  in  8  dividend, sampled on LOAD edge
- BBus  in  4  divisor, sampled on LOAD edge
- ready  out  1  high in IDLE; result valid while high
- resultBus  out  12  {Rreg[3:0], Qreg[7:0]} = {remainder, quotient}
- dbz  out  1  divide-by-zero flag for the last operation (see Configuration)

## Operation
- Registers:
  - Qreg[7:0]: dividend shifts out of the MSB, quotient bits shift into the LSB
  - Rreg[3:0]: partial remainder
  - Dreg[3:0]: divisor
  - cnt[2:0]: step counter
- State machine, one-hot; states IDLE, LOAD, SUB.
  - IDLE: ready=1. If start=1, go to LOAD; otherwise stay in IDLE.
  - LOAD:
    - Qreg<=ABus, Dreg<=BBus, Rreg<=0, cnt<=0, dbz<=0.
    - Go to SUB. With the macro enabled and BBus==0, go to IDLE instead (see Configuration).
  - SUB: one restoring step per cycle.
    - T[4:0] = {Rreg, Qreg[7]}.
    - If T >= {1'b0, Dreg}: Rreg<=T-Dreg (fits 4 bits), Qreg<={Qreg[6:0],1}.
    - Otherwise: Rreg<=T[3:0], Qreg<={Qreg[6:0],0}.
    - cnt<=cnt+1. When cnt==7, go to IDLE after this step.
- Arithmetic: unsigned only. Quotient is 8 bits, so no overflow case exists.
- start is ignored in LOAD and SUB.
- If start is still high on return to IDLE, a new operation starts immediately (level-sensitive, back-to-back).
- resultBus reflects live registers. It is defined only while ready=1 and holds until the next LOAD edge.
- Reset (rst=1 at a rising edge): state=IDLE, Qreg=Rreg=Dreg=0, cnt=0, dbz=0. A reset mid-operation aborts it; no partial result is guaranteed.

## Timing
- Edges are numbered from E0, the edge that samples start=1 in IDLE.
  - E0: IDLE→LOAD; ready falls after E0.
  - E1: operands loaded; the driver must hold ABus/BBus valid from start assertion through E1.
  - E2..E9: eight SUB steps.
  - After E9: state=IDLE, ready=1, resultBus final.
- Latency: 9 cycles from start sample to ready; ready low for exactly 9 cycles.
- Divide-by-zero fast path (macro enabled): ready=1 and dbz=1 after E1; ready low for 1 cycle.
- Output values after reset: ready=1, resultBus=12'h000, dbz=0.

## Configuration
- Macro: DIV_ZERO_CHECK_EN.
- Defined:
  - BBus==0 at LOAD skips SUB and returns to IDLE after E1.
  - Result: dbz=1, Qreg=8'hFF, Rreg=ABus[3:0].
  - dbz clears on the next LOAD.
- Undefined:
  - No zero detection; dbz is tied 0.
  - Divisor 0 runs the full 8 steps. Every compare passes, giving Qreg=8'hFF and Rreg=ABus[3:0] after E9.
- The result value is identical in both builds; only latency and dbz differ.

## Test plan
- 200/7: ABus=8'd200, BBus=4'd7, start pulse → ready high 9 cycles after start sample, resultBus={4'd4, 8'd28} = 12'h41C.
- Boundaries:
  - 255/1 → {4'd0, 8'hFF}.
  - 13/15 → {4'd13, 8'h00}.
  - 0/5 → 12'h000; dbz=0 in all three cases.
- Divide by zero, 8'hA6/0:
  - Macro on: ready after 1 cycle, dbz=1, resultBus=12'h6FF.
  - Macro off: ready after 9 cycles, dbz=0, resultBus=12'h6FF.
- start toggled and operands changed during SUB → ignored; the result matches the operands captured at E1.
- start held high across two operations (200/7 then 99/4) → second LOAD immediately follows IDLE; results 12'h41C then {4'd3, 8'd24} = 12'h318.
- rst asserted at step 4 of SUB → next cycle ready=1, resultBus=0, dbz=0. A new 100/9 then yields {4'd1, 8'd11} = 12'h10B.
